scinstmem_loader: RTL and testbench
===================================

// Module: scinstmem_loader
// PURPOSE
//  Writer side of the single-cycle CPU instruction store: a byte-stream loader that fills a
//  32-bit-word instruction RAM, then releases the CPU. The CPU-facing read port is
//  combinational (inst = ram[a[AW+1:2]]), so it is a drop-in replacement for the
//  fixed ROM once loading completes.
//  Sits between a host byte source (UART/JTAG shim) and the fetch stage; drives cpu_hold.
// PARAMETERS
//  AW     5   word-address bits; RAM depth = 2**AW words
//  NWORDS 32  words per load image; range 1..2**AW
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   synchronous, active-high reset
//  start       in   1   one-cycle pulse; begins a load
//  byte_valid  in   1   host byte present
//  byte_data   in   8   host byte; big-endian, first byte = inst[31:24]
//  byte_ready  out  1   loader accepts byte_data this cycle
//  a           in   32  CPU fetch address (byte address; a[1:0] ignored)
//  inst        out  32  instruction word at a[AW+1:2], combinational
//  busy        out  1   load in progress
//  done        out  1   image loaded; held until next start or reset
//  cpu_hold    out  1   hold CPU in reset/stall while 1
//  err         out  1   checksum mismatch (CHECKSUM_EN only; else constant 0)
// BEHAVIOUR
//  - Reset values: byte_ready=0, busy=0, done=0, cpu_hold=1, err=0. State=IDLE; waddr and
//    byte_idx are cleared. RAM contents are not reset.
//  - States: IDLE -> (start) LOAD -> (NWORDS-th word written) DONE [-> CHECK with CHECKSUM_EN].
//  - IDLE: cpu_hold=1, byte_ready=0. start -> LOAD with waddr=0, byte_idx=0, checksum=0.
//  - LOAD: byte_ready=1, busy=1. A byte is accepted on a clock with byte_valid&byte_ready.
//    The word shifts left: wbuf = {wbuf[23:0], byte_data}. byte_idx counts 0..3.
//    On the 4th byte, {wbuf[23:0], byte_data} is written to ram[waddr] at that same edge,
//    waddr increments, and byte_idx wraps to 0. No extra cycle is used for the write.
//  - After the write with waddr==NWORDS-1: go to DONE. byte_ready drops the next cycle.
//  - Throughput: 1 byte/clock; NWORDS*4 accepting cycles minimum.
//  - DONE: done=1, cpu_hold=0, busy=0, byte_ready=0.
//  - start in DONE: reload. Go to LOAD, done=0, cpu_hold=1 the next cycle; counters cleared.
//  - start while in LOAD is ignored; the load continues.
//  - byte_valid outside LOAD is ignored and never consumed.
//  - inst is combinational in every state. A read of the word being written returns the old
//    value until the write edge. Addresses >= NWORDS return stale RAM contents.
//  - Reset mid-load: return to IDLE immediately, cpu_hold=1, partial word discarded.
//    Already-written words remain in RAM.
//  - start and reset in the same cycle: reset wins.
// CONFIGURATION
//  CHECKSUM_EN defined:
//  - After the last word, the FSM enters CHECK with byte_ready=1 and busy=1.
//  - One more byte is accepted and compared with the XOR of all NWORDS*4 image bytes.
//  - Match: go to DONE, err=0.
//  - Mismatch: go to IDLE, err=1, cpu_hold stays 1. err is cleared by the next start or reset.
//  CHECKSUM_EN undefined:
//  - No CHECK state; LOAD goes directly to DONE. err is tied to 0.
// TESTING
//  T1 reset -> cpu_hold=1, done=0, busy=0, byte_ready=0, err=0 on the first post-reset clock.
//  T2 start; stream 128 bytes, byte_valid held 1; word0 bytes 3C 01 00 00 ->
//     done=1 exactly 128 accepting clocks after start; a=0 gives inst=32'h3c010000;
//     a=32'h7c gives the last loaded word.
//  T3 byte_valid toggles 1/0 every cycle -> same RAM image as T2; done after 255 clocks.
//  T4 reset after 10 bytes, then start with a full image -> inst at a=8 equals new word 2.
//     Bytes 8..9 from the aborted pass do not leak into the new word 2.
//  T5 start pulses mid-load and byte_valid pulses in DONE -> no effect.
//     start in DONE -> cpu_hold=1, reload works.
//  T6 (CHECKSUM_EN) correct XOR byte -> done=1, err=0.
//     Corrupted checksum byte (XOR^8'h01) -> err=1, cpu_hold=1, done=0.

Source files
------------

// File: rtl/scinstmem_loader.sv
// Byte-stream loader for the CPU instruction RAM. The CPU fetch port is combinational.
// Optional checksum stage enabled by defining CHECKSUM_EN.
module scinstmem_loader #(
    parameter int unsigned AW     = 5,
    parameter int unsigned NWORDS = 32
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    input  logic [31:0] a_i,
    output logic [31:0] inst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        cpu_hold_o,
    output logic        err_o
);

    localparam logic [AW-1:0] LastAddr = AW'(NWORDS - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StDone, StCheck} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [1:0]      idx_q, idx_d;
    logic [23:0]     wbuf_q, wbuf_d;
    logic            we;
    logic [31:0]     mem_q [2**AW];
`ifdef CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        idx_d   = idx_q;
        wbuf_d  = wbuf_q;
        we      = 1'b0;
`ifdef CHECKSUM_EN
        csum_d  = csum_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StLoad;
                    waddr_d = '0;
                    idx_d   = '0;
`ifdef CHECKSUM_EN
                    csum_d  = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            StLoad: begin
                if (byte_valid_i) begin
                    wbuf_d = {wbuf_q[15:0], byte_data_i};
                    idx_d  = idx_q + 2'd1;
`ifdef CHECKSUM_EN
                    csum_d = csum_q ^ byte_data_i;
`endif
                    if (idx_q == 2'd3) begin
                        we      = 1'b1;
                        waddr_d = waddr_q + AW'(1);
                        if (waddr_q == LastAddr) begin
`ifdef CHECKSUM_EN
                            state_d = StCheck;
`else
                            state_d = StDone;
`endif
                        end
                    end
                end
            end
            StCheck: begin
`ifdef CHECKSUM_EN
                if (byte_valid_i) begin
                    if (byte_data_i == csum_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            waddr_q <= '0;
            idx_q   <= '0;
            wbuf_q  <= '0;
`ifdef CHECKSUM_EN
            csum_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            idx_q   <= idx_d;
            wbuf_q  <= wbuf_d;
`ifdef CHECKSUM_EN
            csum_q  <= csum_d;
            err_q   <= err_d;
`endif
        end
    end

    // RAM contents survive reset; only the write of a completing word is suppressed.
    always_ff @(posedge clk_i) begin
        if (we && !reset_i) begin
            mem_q[waddr_q] <= {wbuf_q, byte_data_i};
        end
    end

    logic unused_a;
    assign unused_a = ^{a_i[31:AW+2], a_i[1:0]};

    assign inst_o       = mem_q[a_i[AW+1:2]];
    assign byte_ready_o = (state_q == StLoad) || (state_q == StCheck);
    assign busy_o       = byte_ready_o;
    assign done_o       = (state_q == StDone);
    assign cpu_hold_o   = (state_q != StDone);
`ifdef CHECKSUM_EN
    assign err_o        = err_q;
`else
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_scinstmem_loader.sv
// Self-checking bench for scinstmem_loader: control-vector table plus a word scoreboard.
module tb_scinstmem_loader;

    localparam int AW = 5;
    localparam int NW = 32;
    localparam int NB = NW * 4;

    logic        clk = 1'b0;
    logic        reset, start, byte_valid, byte_ready;
    logic [7:0]  byte_data;
    logic [31:0] a, inst;
    logic        busy, done, cpu_hold, err;

    always #5 clk = ~clk;

    scinstmem_loader #(.AW(AW), .NWORDS(NW)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .byte_valid_i(byte_valid),
        .byte_data_i (byte_data),
        .byte_ready_o(byte_ready),
        .a_i         (a),
        .inst_o      (inst),
        .busy_o      (busy),
        .done_o      (done),
        .cpu_hold_o  (cpu_hold),
        .err_o       (err)
    );

    // exp = {byte_ready, busy, done, cpu_hold, err}
    typedef struct {
        logic       rst;
        logic       st;
        logic       vld;
        logic [4:0] exp;
        string      name;
    } vec_t;

    typedef struct {
        int          addr;
        logic [31:0] word;
    } sb_t;

    vec_t        vecs[6];
    sb_t         sbq[$];
    logic [7:0]  img[NB];
    logic [31:0] exp_mem[NW];
    bit          known[NW];
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic logic [4:0] status();
        return {byte_ready, busy, done, cpu_hold, err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic make_img(input int seed);
        for (int i = 0; i < NB; i++) img[i] = 8'((i * 37 + seed * 11 + 5) ^ (i >> 3));
        if (seed == 1) begin
            img[0] = 8'h3c; img[1] = 8'h01; img[2] = 8'h00; img[3] = 8'h00;
        end
    endtask

    task automatic load(input int seed, input bit toggle, input int nbytes, input bit poke,
                        input bit corrupt);
        int          i = 0;
        int          cyc = 0;
        int          total;
        int          limit;
        logic [7:0]  xs = 8'h00;
        logic [31:0] w;
        make_img(seed);
        total = NB;
`ifdef CHECKSUM_EN
        total = NB + 1;
`endif
        limit = (nbytes == NB) ? total : nbytes;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("load_entry", 32'(status()), 32'(5'b11010));
        while (i < limit && cyc < 600) begin
            @(negedge clk);
            byte_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            start      = poke && (i == 50);
            byte_data  = (i < NB) ? img[i] : (xs ^ (corrupt ? 8'h01 : 8'h00));
            if (byte_valid && i < NB && i % 4 == 3) begin
                a = 32'((i / 4) * 4);
                #1;
                if (known[i/4]) check("read_old", inst, exp_mem[i/4]);
            end
            @(posedge clk);
            cyc++;
            if (byte_valid) begin
                if (i < NB) begin
                    xs ^= img[i];
                    if (i % 4 == 3) begin
                        w = {img[i-3], img[i-2], img[i-1], img[i]};
                        exp_mem[i/4] = w;
                        known[i/4]   = 1'b1;
                        if (nbytes == NB) sbq.push_back('{i / 4, w});
                    end
                end
                i++;
            end
            #1;
            if (nbytes == NB) check("done_flag", 32'(done), 32'(i == total && !corrupt));
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        a          = 32'h0;
        if (nbytes == NB) begin
            check("load_cycles", cyc, toggle ? 2 * total - 1 : total);
            if (corrupt) check("chk_bad_status", 32'(status()), 32'(5'b00011));
            else         check("done_status", 32'(status()), 32'(5'b00100));
            while (sbq.size() > 0) begin
                sb_t e = sbq.pop_front();
                a = 32'(e.addr * 4) + $urandom_range(0, 3);
                #1 check("inst_word", inst, e.word);
            end
            a = 32'h0;
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 5'b00010, "reset"};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 5'b00010, "idle_valid_ignored"};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 5'b11010, "start_to_load"};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 5'b11010, "start_in_load"};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 5'b00010, "reset_beats_start"};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 5'b00010, "idle_after_reset"};

        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; a = 32'h0;
        for (int k = 0; k < NW; k++) known[k] = 1'b0;
        repeat (2) @(posedge clk);

        foreach (vecs[k]) begin
            @(negedge clk);
            reset = vecs[k].rst; start = vecs[k].st; byte_valid = vecs[k].vld;
            @(posedge clk);
            #1 check(vecs[k].name, 32'(status()), 32'(vecs[k].exp));
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0; byte_valid = 1'b0;

        // Full image, byte_valid held high.
        load(1, 1'b0, NB, 1'b0, 1'b0);
        a = 32'h0;
        #1 check("word0_literal", inst, 32'h3c010000);
        a = 32'h7c;
        #1 check("last_word", inst, {img[124], img[125], img[126], img[127]});
        a = 32'h0;

        // Same image with byte_valid toggling.
        load(1, 1'b1, NB, 1'b0, 1'b0);

        // Abort after 10 bytes, then a fresh full image.
        load(2, 1'b0, 10, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 check("mid_load_reset", 32'(status()), 32'(5'b00010));
        reset = 1'b0;
        load(3, 1'b0, NB, 1'b0, 1'b0);
        a = 32'h8;
        #1 check("word2_after_abort", inst, {img[8], img[9], img[10], img[11]});
        a = 32'h0;

        // Start pulse mid-load, then stray bytes in DONE, then reload.
        load(4, 1'b0, NB, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'haa;
            @(posedge clk);
            #1 check("valid_in_done", 32'(status()), 32'(5'b00100));
        end
        @(negedge clk);
        byte_valid = 1'b0;
        load(5, 1'b0, NB, 1'b0, 1'b0);

`ifdef CHECKSUM_EN
        load(6, 1'b0, NB, 1'b0, 1'b1);
        load(7, 1'b0, NB, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
